// File: rtl/aes_pio_block_assembler.sv
// Bridges HPS PIOs to an AES core. Four 32-bit words are assembled into a
// 128-bit block, the block is handed off over valid/ready, and the 128-bit
// result is captured and read back one word at a time.
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   data_in[31:0]          : word from the HPS data PIO
//   ctrl_in[7:0]           : [0] load toggle, [2:1] word index, [3] start toggle, [4] clear
//   blk_data/valid/ready   : plaintext block handshake to the AES core
//   res_data/valid/ready   : result handshake from the AES core
//   rdata_out[31:0]        : result word selected by ctrl_in[2:1]
//   status_out[31:0]       : {15'b0, block count, mask, err, done, busy, state}
module aes_pio_block_assembler #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_W          = 11
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [31:0]  data_in,
   input  logic [7:0]   ctrl_in,
   output logic [127:0] blk_data,
   output logic         blk_valid,
   input  logic         blk_ready,
   input  logic [127:0] res_data,
   input  logic         res_valid,
   output logic         res_ready,
   output logic [31:0]  rdata_out,
   output logic [31:0]  status_out
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state_q,     state_n;
   logic [7:0]       ctrl_d_q;
   logic [127:0]     blk_data_q,  blk_data_n;
   logic             blk_valid_q, blk_valid_n;
   logic             res_ready_q, res_ready_n;
   logic [3:0]       mask_q,      mask_n;
   logic             err_q,       err_n;
   logic [7:0]       blk_cnt_q,   blk_cnt_n;
   logic [CNT_W-1:0] tmo_cnt_q,   tmo_cnt_n;
   logic [127:0]     res_buf_q,   res_buf_n;
   logic [31:0]      rdata_q,     rdata_n;
   logic [31:0]      status_q,    status_n;

   logic       load_ev_c, start_ev_c, clear_c;
   logic [1:0] idx_c;
   logic [6:0] bit_base_c;

   // Toggle-style events from the software PIO: any change of the bit is an event.
   assign load_ev_c  = ctrl_in[0] ^ ctrl_d_q[0];
   assign start_ev_c = ctrl_in[3] ^ ctrl_d_q[3];
   assign clear_c    = ctrl_in[4];
   assign idx_c      = ctrl_in[2:1];
   assign bit_base_c = {idx_c, 5'b00000};

   // Next-state and next-output logic.
   always_comb begin
      state_n     = state_q;
      blk_data_n  = blk_data_q;
      blk_valid_n = blk_valid_q;
      res_ready_n = res_ready_q;
      mask_n      = mask_q;
      err_n       = err_q;
      blk_cnt_n   = blk_cnt_q;
      tmo_cnt_n   = tmo_cnt_q;
      res_buf_n   = res_buf_q;

      if (clear_c) begin
         // Clear wins over everything and abandons any handshake in flight.
         state_n     = S_IDLE;
         blk_valid_n = 1'b0;
         res_ready_n = 1'b0;
         mask_n      = 4'h0;
         err_n       = 1'b0;
         res_buf_n   = '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               // Load is applied first so a same-cycle start sees the new mask bit.
               if (load_ev_c) begin
                  blk_data_n[bit_base_c +: 32] = data_in;
                  mask_n = mask_q | (4'(1) << idx_c);
               end
               if (start_ev_c) begin
                  if (mask_n == 4'hF) begin
                     state_n     = S_SEND;
                     blk_valid_n = 1'b1;
                  end else begin
                     err_n = 1'b1;
                  end
               end
            end
            S_SEND: begin
               if (load_ev_c || start_ev_c) err_n = 1'b1;
               if (blk_valid_q && blk_ready) begin
                  blk_valid_n = 1'b0;
                  mask_n      = 4'h0;
                  res_ready_n = 1'b1;
                  tmo_cnt_n   = '0;
                  state_n     = S_WAIT;
               end
            end
            S_WAIT: begin
               if (load_ev_c || start_ev_c) err_n = 1'b1;
               if (res_valid && res_ready_q) begin
                  res_buf_n   = res_data;
                  res_ready_n = 1'b0;
                  blk_cnt_n   = blk_cnt_q + 8'd1;
                  state_n     = S_DONE;
               end else if (TIMEOUT_CYCLES != 0) begin
                  // Abort once TIMEOUT_CYCLES waiting cycles have elapsed.
                  tmo_cnt_n = tmo_cnt_q + CNT_W'(1);
                  if (tmo_cnt_n == CNT_W'(TIMEOUT_CYCLES)) begin
                     err_n       = 1'b1;
                     res_ready_n = 1'b0;
                     state_n     = S_IDLE;
                  end
               end
            end
            default: state_n = S_IDLE;
         endcase
      end

      rdata_n  = res_buf_q[bit_base_c +: 32];
      status_n = {15'h0000, blk_cnt_q, mask_q, err_q, (state_q == S_DONE),
                  (state_q == S_SEND) || (state_q == S_WAIT), state_q};
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         ctrl_d_q    <= 8'h00;
         blk_data_q  <= '0;
         blk_valid_q <= 1'b0;
         res_ready_q <= 1'b0;
         mask_q      <= 4'h0;
         err_q       <= 1'b0;
         blk_cnt_q   <= 8'h00;
         tmo_cnt_q   <= '0;
         res_buf_q   <= '0;
         rdata_q     <= 32'h0;
         status_q    <= 32'h0;
      end else begin
         state_q     <= state_n;
         ctrl_d_q    <= ctrl_in;
         blk_data_q  <= blk_data_n;
         blk_valid_q <= blk_valid_n;
         res_ready_q <= res_ready_n;
         mask_q      <= mask_n;
         err_q       <= err_n;
         blk_cnt_q   <= blk_cnt_n;
         tmo_cnt_q   <= tmo_cnt_n;
         res_buf_q   <= res_buf_n;
         rdata_q     <= rdata_n;
         status_q    <= status_n;
      end
   end

   assign blk_data   = blk_data_q;
   assign blk_valid  = blk_valid_q;
   assign res_ready  = res_ready_q;
   assign rdata_out  = rdata_q;
   assign status_out = status_q;

endmodule

// File: tb/tb_aes_pio_block_assembler.sv
// Scoreboard bench for aes_pio_block_assembler. Stimulus pushes expected
// values into queues; a negedge monitor pops and compares them, and checks
// every block handshake against the expected-block queue.
module tb_aes_pio_block_assembler;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [31:0]  data_in;
   logic [7:0]   ctrl_in;
   logic [127:0] blk_data;
   logic         blk_valid;
   logic         blk_ready;
   logic [127:0] res_data;
   logic         res_valid;
   logic         res_ready;
   logic [31:0]  rdata_out;
   logic [31:0]  status_out;

   logic       ld_t, st_t, clr;
   logic [1:0] idx;
   assign ctrl_in = {3'b000, clr, st_t, idx, ld_t};

   aes_pio_block_assembler #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
      .clk(clk), .reset_n(reset_n), .data_in(data_in), .ctrl_in(ctrl_in),
      .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .rdata_out(rdata_out), .status_out(status_out)
   );

   always #5 clk = ~clk;

   localparam int K_STATUS = 0, K_RDATA = 1, K_BVALID = 2, K_RREADY = 3,
                  K_BDATA = 4, K_VRUN = 5, K_RRUN = 6;

   typedef struct {
      int           kind;
      string        name;
      logic [127:0] val;
   } exp_t;

   exp_t         exp_q[$];
   logic [127:0] exp_blk_q[$];

   int n_chk  = 0;
   int n_pass = 0;

   int           vrun_cur = 0, vrun_last = 0, rrun_cur = 0, rrun_last = 0;
   logic         prev_valid = 1'b0;
   logic [127:0] prev_data  = '0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic expect_val(input int kind, input string nm, input logic [127:0] v);
      exp_t e;
      e.kind = kind; e.name = nm; e.val = v;
      exp_q.push_back(e);
   endtask

   // Monitor: run lengths, block stability, handshakes, then drain expectations.
   always @(negedge clk) begin
      logic [127:0] act;
      if (blk_valid) vrun_cur++;
      else if (vrun_cur != 0) begin vrun_last = vrun_cur; vrun_cur = 0; end
      if (res_ready) rrun_cur++;
      else if (rrun_cur != 0) begin rrun_last = rrun_cur; rrun_cur = 0; end

      if (blk_valid && prev_valid) chk("blk_data_stable", blk_data, prev_data);
      prev_valid = blk_valid;
      prev_data  = blk_data;

      if (blk_valid && blk_ready) begin
         if (exp_blk_q.size() == 0) chk("unexpected_block", blk_data, 128'hx);
         else chk("blk_handshake", blk_data, exp_blk_q.pop_front());
      end

      while (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         case (e.kind)
            K_STATUS: act = {96'h0, status_out};
            K_RDATA:  act = {96'h0, rdata_out};
            K_BVALID: act = {127'h0, blk_valid};
            K_RREADY: act = {127'h0, res_ready};
            K_BDATA:  act = blk_data;
            K_VRUN:   act = 128'(vrun_last);
            K_RRUN:   act = 128'(rrun_last);
            default:  act = 'x;
         endcase
         chk(e.name, act, e.val);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic load_word(input logic [1:0] i, input logic [31:0] w);
      data_in = w; idx = i; ld_t = ~ld_t; tick();
   endtask

   task automatic load_block(input logic [127:0] b);
      for (int i = 0; i < 4; i++) load_word(2'(i), b[32*i +: 32]);
   endtask

   task automatic start_tog();
      st_t = ~st_t; tick();
   endtask

   task automatic finish_block(input logic [127:0] r);
      blk_ready = 1'b1; tick(); blk_ready = 1'b0;
      res_data = r; res_valid = 1'b1; tick(); res_valid = 1'b0;
   endtask

   task automatic do_clear();
      clr = 1'b1; tick(); clr = 1'b0; tick();
   endtask

   localparam logic [127:0] B1 = 128'hCCDDEEFF_8899AABB_44556677_00112233;
   localparam logic [127:0] R1 = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
   localparam logic [127:0] B2 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
   localparam logic [127:0] R2 = 128'h11111111_22222222_33333333_44444444;
   localparam logic [127:0] B3 = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
   localparam logic [127:0] R3 = 128'hFEEDFACE_CAFEBABE_12345678_9ABCDEF0;
   localparam logic [127:0] B4 = 128'h55555555_AAAAAAAA_5A5A5A5A_A5A5A5A5;

   initial begin
      logic [127:0] b, r;
      logic [31:0]  rw [4];
      reset_n = 1'b0; data_in = '0; blk_ready = 1'b0; res_data = '0; res_valid = 1'b0;
      ld_t = 1'b0; st_t = 1'b0; clr = 1'b0; idx = 2'd0;
      #1;
      expect_val(K_STATUS, "rst_status", 128'h0);
      expect_val(K_RDATA,  "rst_rdata",  128'h0);
      expect_val(K_BVALID, "rst_bvalid", 128'h0);
      expect_val(K_RREADY, "rst_rready", 128'h0);
      expect_val(K_BDATA,  "rst_bdata",  128'h0);
      tick(); tick();
      reset_n = 1'b1;
      tick();

      // Full block, delayed ready, result capture and readback sweep.
      load_block(B1);
      expect_val(K_BDATA, "assembled_block", B1);
      tick();
      expect_val(K_STATUS, "mask_full", 128'h1E0);
      exp_blk_q.push_back(B1);
      start_tog();
      repeat (5) tick();
      blk_ready = 1'b1; tick(); blk_ready = 1'b0;
      expect_val(K_VRUN,   "valid_cycles", 128'd6);
      expect_val(K_RREADY, "res_ready_up", 128'h1);
      tick();
      expect_val(K_STATUS, "wait_res_status", 128'h6);
      res_data = R1; res_valid = 1'b1; tick(); res_valid = 1'b0;
      tick();
      expect_val(K_STATUS, "done_status", 128'h20B);
      rw[0] = 32'h70B4C55A; rw[1] = 32'hD8CDB780; rw[2] = 32'h6A7B0430; rw[3] = 32'h69C4E0D8;
      for (int i = 0; i < 4; i++) begin
         idx = 2'(i); tick();
         expect_val(K_RDATA, $sformatf("rdata_%0d", i), {96'h0, rw[i]});
      end

      // Clear, then start with an incomplete mask.
      do_clear();
      expect_val(K_STATUS, "clear_status", 128'h200);
      expect_val(K_RDATA,  "clear_rdata",  128'h0);
      load_word(2'd0, 32'h1); load_word(2'd1, 32'h2);
      start_tog(); tick();
      expect_val(K_STATUS, "incomplete_start", 128'h270);
      expect_val(K_BVALID, "no_valid", 128'h0);
      do_clear();
      expect_val(K_STATUS, "clear_err", 128'h200);

      // Load during SEND is ignored and flags err.
      load_block(B2);
      exp_blk_q.push_back(B2);
      start_tog();
      load_word(2'd0, 32'hDEADBEEF);
      tick();
      expect_val(K_STATUS, "load_in_send", 128'h3F5);
      expect_val(K_BDATA,  "send_data_held", B2);
      finish_block(R2);
      do_clear();

      // Last load and start in the same cycle.
      for (int i = 0; i < 3; i++) load_word(2'(i), B3[32*i +: 32]);
      exp_blk_q.push_back(B3);
      data_in = B3[127:96]; idx = 2'd3; ld_t = ~ld_t; st_t = ~st_t; tick();
      tick();
      expect_val(K_STATUS, "simul_load_start", 128'h5E5);
      finish_block(R3);
      tick();
      expect_val(K_STATUS, "done_cnt3", 128'h60B);

      // Result timeout.
      load_block(B4);
      exp_blk_q.push_back(B4);
      start_tog();
      blk_ready = 1'b1; tick(); blk_ready = 1'b0;
      repeat (20) tick();
      expect_val(K_RRUN,   "timeout_cycles", 128'd16);
      expect_val(K_STATUS, "timeout_status", 128'h610);
      expect_val(K_RREADY, "timeout_rready", 128'h0);
      expect_val(K_RDATA,  "timeout_res_kept", {96'h0, R3[127:96]});
      do_clear();

      // Asynchronous reset in the middle of SEND.
      load_block(B4);
      start_tog();
      reset_n = 1'b0; ld_t = 1'b0; st_t = 1'b0; idx = 2'd0;
      expect_val(K_BVALID, "midrst_bvalid", 128'h0);
      expect_val(K_BDATA,  "midrst_bdata",  128'h0);
      expect_val(K_STATUS, "midrst_status", 128'h0);
      expect_val(K_RDATA,  "midrst_rdata",  128'h0);
      expect_val(K_RREADY, "midrst_rready", 128'h0);
      tick(); tick();
      reset_n = 1'b1;
      tick();

      // 256 blocks wrap the block counter.
      for (int n = 0; n < 256; n++) begin
         b = {32'(n) ^ 32'hFFFF0000, 32'(n) << 8, 32'h5A5A0000 | 32'(n), 32'h00C30000 | 32'(n)};
         r = {4{32'hC0DE0000 | 32'(n)}};
         load_block(b);
         exp_blk_q.push_back(b);
         start_tog();
         finish_block(r);
         if (n == 254) begin
            tick();
            expect_val(K_STATUS, "cnt_255", 128'h1FE0B);
         end
      end
      tick();
      expect_val(K_STATUS, "cnt_wrap", 128'h0000000B);
      expect_val(K_RDATA,  "last_result", 128'hC0DE00FF);

      repeat (3) tick();
      chk("exp_q_drained", 128'(exp_q.size()), 128'd0);
      chk("blk_q_drained", 128'(exp_blk_q.size()), 128'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/aes_pio_block_assembler.md
Name: aes_pio_block_assembler

Overview:
- Sits directly downstream of the HPS 32-bit data output PIO and a second 8-bit HPS control output PIO.
- Assembles four 32-bit words written by software into a 128-bit block.
- Hands the block to the AES core over a valid/ready handshake, then captures the 128-bit result.
- Exposes result words and a status word for HPS input PIOs to read back.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles in WAIT_RES before abort; 0 disables timeout
CNT_W, 11, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
data_in  in  32  word from HPS data PIO out_port
ctrl_in  in  8  [0] load toggle, [2:1] word index, [3] start toggle, [4] clear level, [7:5] unused
blk_data  out  128  assembled plaintext block to AES core
blk_valid  out  1  block valid
blk_ready  in  1  AES core accepts block
res_data  in  128  AES result
res_valid  in  1  result valid
res_ready  out  1  block accepts result
rdata_out  out  32  result word selected by ctrl_in[2:1]
status_out  out  32  status word to HPS input PIO

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk.
  - State IDLE; blk_data, result buffer, rdata_out, status_out all 0.
  - blk_valid=0, res_ready=0, load mask 0, err 0, block counter 0.
  - ctrl_d (previous ctrl_in) is reset to 0.
- Events:
  - Registered edge detect with ctrl_d <= ctrl_in every cycle.
  - load_ev = ctrl_in[0]^ctrl_d[0]; start_ev = ctrl_in[3]^ctrl_d[3]. Either toggle direction counts.
- Load:
  - In IDLE or DONE, load_ev writes data_in into blk_data[32*i+31:32*i], i=ctrl_in[2:1], and sets mask[i].
  - Word 0 = bits [31:0].
  - A load_ev in SEND or WAIT_RES is ignored and sets err.
- Start:
  - In IDLE or DONE, start_ev with mask==4'hF moves to SEND and sets blk_valid=1 on the next cycle.
  - start_ev with mask incomplete: ignored, sets err.
  - start_ev in SEND or WAIT_RES: ignored, sets err.
- Simultaneous load_ev and start_ev: the load is applied first, and start is evaluated against the mask including that load.
- State machine (status encoding IDLE=0, SEND=1, WAIT_RES=2, DONE=3):
  - SEND: blk_valid held high and blk_data held stable until blk_ready. On blk_valid&&blk_ready: blk_valid=0, mask cleared, go to WAIT_RES, res_ready=1, timeout counter cleared.
  - WAIT_RES: on res_valid&&res_ready, capture res_data, res_ready=0, block counter +1 (8-bit, wraps 255->0), go to DONE.
  - WAIT_RES timeout: if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES with no result, set err, res_ready=0, go to IDLE. The result buffer is unchanged.
  - DONE: behaves like IDLE for load/start. The result is held until the next capture or clear.
- Clear: ctrl_in[4]=1 (level) has priority over all events.
  - Next cycle: state IDLE, blk_valid=0, res_ready=0, mask 0, err 0, result buffer 0, block counter retained.
  - An in-flight AES handshake is abandoned; the bench must tolerate a dropped valid.
  - Events are not acted on while clear is high, but ctrl_d still tracks ctrl_in.
- rdata_out: registered result word ctrl_in[2:1] of the result buffer; 1-cycle latency from an index or result change.
- status_out: registered, 1-cycle latency.
  - [1:0] state, [2] busy (SEND|WAIT_RES), [3] done (state==DONE), [4] err sticky.
  - [8:5] mask, [16:9] block counter, [31:17] 0.

Test Plan:
- Load words 0x00112233,0x44556677,0x8899AABB,0xCCDDEEFF to i=0..3 via toggles -> mask=F, blk_data=0xCCDDEEFF_8899AABB_44556677_00112233, status[8:5]=4'hF.
- Start with blk_ready held 0 for 5 cycles then 1 -> blk_valid high 6 cycles, data stable; then state=2, res_ready=1, mask=0. Return res_data=0x69C4E0D8_6A7B0430_D8CDB780_70B4C55A with res_valid -> state=3, counter=1. Index sweep 0..3 -> rdata_out 0x70B4C55A,0xD8CDB780,0x6A7B0430,0x69C4E0D8 one cycle after each index.
- Start after loading only words 0,1 -> stays IDLE, blk_valid never asserts, status[4]=1. Clear -> err=0, mask=0.
- Load toggle during SEND -> blk_data unchanged, err=1.
- Load word 3 and start toggle in the same cycle with words 0..2 loaded -> SEND entered.
- TIMEOUT_CYCLES=16 with no res_valid -> after 16 WAIT_RES cycles state=IDLE, err=1, res_ready=0.
- Assert reset_n=0 mid-SEND -> all outputs 0 immediately.
- 256 complete blocks -> counter wraps to 0.
